branch_ctrl: RTL
================

// Module: branch_ctrl
// PURPOSE
//  Sequences control flow after the EX-stage branch unit resolves a branch or jump.
//  Turns a taken decision into a fetch redirect with a valid/ready handshake.
//  Flushes the wrong-path IF/ID slots and raises a trap pulse on a misaligned target.
//  Sits between the EX stage (branch unit + ALU target) and the fetch unit / pipeline registers.
// PARAMETERS
//  XLEN          32  data/address width
//  FLUSH_CYCLES  2   cycles of wrong-path fetch to kill after redirect accept (0..15)
//  CNT_W         16  width of taken-redirect statistics counter
// PORTS
//  i_clk             in   1     clock
//  i_rst             in   1     synchronous reset, active-high
//  i_ex_valid        in   1     EX stage holds a valid instruction
//  i_opcode          in   5     instr[6:2] of EX instruction
//  i_branch_en       in   1     branch unit result: take branch/jump
//  i_target          in   XLEN  computed target address (ALU)
//  i_fetch_ready     in   1     fetch unit accepts redirect this cycle
//  o_redirect_valid  out  1     redirect request to fetch
//  o_redirect_pc     out  XLEN  redirect target; stable while valid && !ready
//  o_flush_if        out  1     invalidate IF/ID pipeline register
//  o_flush_id        out  1     invalidate ID/EX pipeline register
//  o_stall_ex        out  1     hold EX stage (redirect pending, not yet accepted)
//  o_misalign        out  1     1-cycle trap pulse: target not 4-byte aligned
//  o_misalign_addr   out  XLEN  offending target, valid with o_misalign
//  o_taken_cnt       out  CNT_W count of accepted redirects, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0, kill counter 0, taken count 0.
//  - Decision sampled at cycle T when state==IDLE && i_ex_valid && i_branch_en.
//    Decisions in any other state are ignored: no counter change, no pulse.
//  - Effective target: JALR (11001) -> i_target & ~1. Otherwise i_target unchanged.
//  - Misaligned (eff[1]!=0): T+1 o_misalign=1, o_misalign_addr=eff.
//    No redirect, no flush, stay IDLE.
//  - Aligned: T+1 enter REDIRECT with o_redirect_valid=1, o_redirect_pc=eff.
//    o_taken_cnt increments at the T+1 edge.
//  - REDIRECT: o_flush_if=o_flush_id=1. o_stall_ex = !i_fetch_ready.
//    Hold valid/pc until the cycle with i_fetch_ready=1 (handshake).
//  - Handshake -> KILL with kill counter = FLUSH_CYCLES, or -> IDLE if FLUSH_CYCLES==0.
//    o_redirect_valid drops the cycle after the handshake.
//  - KILL: flushes held high, stall low. Counter decrements each cycle; at 1 -> IDLE.
//    Flushes are low in the first IDLE cycle.
//  - Not-taken (i_branch_en=0) or !i_ex_valid: no output activity.
//  - i_rst mid-REDIRECT/KILL: next cycle IDLE, all outputs 0, pending redirect dropped.
//    o_taken_cnt cleared.
//  - o_taken_cnt wraps from 2^CNT_W-1 to 0 without flag.
// STRUCTURE
//  - Shared header branch_defs.vh holds:
//    - opcode localparams OP_BRANCH=11000, OP_JAL=11011, OP_JALR=11001.
//    - FSM state encodings ST_IDLE=2'd0, ST_REDIRECT=2'd1, ST_KILL=2'd2 (2'd3 illegal -> IDLE).
//  - One sub-module flush_timer: loadable 4-bit down-counter with load/zero outputs.
//    It drives the KILL exit condition.
//  - Top holds the FSM, target/alignment logic, output registers and stats counter.
// TESTING
//  1. BEQ taken, target 0x100, fetch_ready=1:
//     T+1 valid=1, pc=0x100. Flushes high T+1..T+3. IDLE at T+4. taken_cnt=1.
//  2. Taken, target 0x2000, fetch_ready low 3 cycles:
//     valid/pc=0x2000 stable and stall_ex=1 for 3 cycles. Ready -> stall 0, KILL 2 cycles.
//  3. JALR target 0x201 -> redirect pc 0x200.
//     JAL target 0x102 -> misalign=1 one cycle, addr=0x102, no redirect, taken_cnt unchanged.
//  4. New taken decision during KILL and during REDIRECT: ignored.
//     pc unchanged, taken_cnt unchanged.
//  5. i_rst asserted in REDIRECT with ready=0: next cycle all outputs 0.
//     Subsequent decision handled normally.
//  6. CNT_W=4, FLUSH_CYCLES=0: 16 taken redirects with ready=1 -> taken_cnt returns to 0.
//     Each redirect is 1 cycle, no KILL.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch control slice.
//  - RV32 opcode field values (instr[6:2]) for the control-transfer instructions.
//  - FSM state encoding used by branch_ctrl (2'd3 is illegal and recovers to IDLE).
package branch_ctrl_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_KILL     = 2'd2
  } state_e;

  // JALR clears bit 0 of its computed target; every other transfer uses it as-is.
  function automatic logic clears_lsb(input logic [4:0] opcode);
    return opcode == OP_JALR;
  endfunction

endpackage

// File: rtl/branch_ctrl_flush_timer.sv
// flush_timer: loadable 4-bit down-counter that times the wrong-path kill window.
// Ports:
//  clk_i       clock
//  rst_i       synchronous active-high reset (count -> 0)
//  load_i      load load_val_i into the counter (has priority over dec_i)
//  load_val_i  value to load
//  dec_i       decrement request; ignored once the counter is at zero
//  zero_o      counter is zero
//  last_o      counter is one (this is the final cycle of the window)
module flush_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o,
  output logic       last_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);
  assign last_o = (count_q == 4'd1);

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: turns a resolved EX-stage branch/jump into a fetch redirect.
// A taken decision with an aligned target raises a redirect (valid/ready to fetch),
// flushes IF/ID while the redirect is pending and for FLUSH_CYCLES after it is
// accepted, and counts accepted decisions. A target with bit 1 set instead produces
// a one-cycle misalign trap pulse with the offending address.
// Ports:
//  i_clk, i_rst             clock, synchronous active-high reset
//  i_ex_valid, i_opcode     EX instruction valid and instr[6:2]
//  i_branch_en, i_target    branch unit decision and ALU target
//  i_fetch_ready            fetch accepts the redirect this cycle
//  o_redirect_valid/_pc     redirect request to fetch
//  o_flush_if, o_flush_id   invalidate IF/ID and ID/EX registers
//  o_stall_ex               hold EX while a redirect waits for fetch
//  o_misalign(_addr)        misaligned-target trap pulse and address
//  o_taken_cnt              taken-redirect statistics, wraps
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_opcode,
  input  logic             i_branch_en,
  input  logic [XLEN-1:0]  i_target,
  input  logic             i_fetch_ready,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic             o_stall_ex,
  output logic             o_misalign,
  output logic [XLEN-1:0]  o_misalign_addr,
  output logic [CNT_W-1:0] o_taken_cnt
);

  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

  state_e            state_q, state_d;
  logic              tmr_load, tmr_dec, tmr_zero, tmr_last;
  logic              decide, mis;
  logic [XLEN-1:0]   eff;

  logic              redirect_valid_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic              flush_q;
  logic              misalign_q;
  logic [XLEN-1:0]   misalign_addr_q;
  logic [CNT_W-1:0]  taken_cnt_q;

  // Decisions only count while idle; anything arriving mid-redirect is dropped.
  assign decide = (state_q == ST_IDLE) && i_ex_valid && i_branch_en;
  assign eff    = clears_lsb(i_opcode) ? {i_target[XLEN-1:1], 1'b0} : i_target;
  assign mis    = eff[1];

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (decide && !mis) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (i_fetch_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_KILL;
            tmr_load = 1'b1;
          end
        end
      end
      ST_KILL: begin
        tmr_dec = 1'b1;
        // zero is a defensive exit; in normal operation last ends the window.
        if (tmr_last || tmr_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  flush_timer u_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (tmr_load),
    .load_val_i (FLUSH_LD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero),
    .last_o     (tmr_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
      misalign_addr_q  <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= (state_d == ST_REDIRECT);
      flush_q          <= (state_d == ST_REDIRECT) || (state_d == ST_KILL);
      misalign_q       <= decide && mis;
      if (decide && mis) misalign_addr_q <= eff;
      if (decide && !mis) begin
        redirect_pc_q <= eff;
        taken_cnt_q   <= taken_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_flush_if       = flush_q;
  assign o_flush_id       = flush_q;
  // The handshake is same-cycle, so stall must follow ready combinationally;
  // it is gated by a registered valid and so cannot glitch from internal state.
  assign o_stall_ex       = redirect_valid_q & ~i_fetch_ready;
  assign o_misalign       = misalign_q;
  assign o_misalign_addr  = misalign_addr_q;
  assign o_taken_cnt      = taken_cnt_q;

endmodule
